mul_long_unit: RTL

Iterative 32x32 multiplier that produces the 64-bit results of UMULL/SMULL and the 32-bit result of MUL.
It sits directly upstream of the register file. It drives the write-back data pair (wd3 = low word, wd4 = high word), the destination addresses (a3, a4), the write-enable and the Long flag.
The control unit holds the pipeline with busy until done.

---
 rtl/mul_long_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mul_long_unit.sv
// Iterative shift-add 32x32 multiplier for UMULL/SMULL/MUL; drives register-file write-back pair.
// Latency: done pulses in the cycle after the 33rd rising edge following the accepted start.
// Backpressure: busy stays high from accept through DONE; start is ignored unless IDLE.
module mul_long_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic             long_en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       rd_lo,
   input  logic [3:0]       rd_hi,
   output logic             busy,
   output logic             done,
   output logic             we,
   output logic             long_out,
   output logic [3:0]       a3,
   output logic [3:0]       a4,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand magnitude
   logic [WIDTH-1:0]   mplr_q,  mplr_d;    // multiplier, shifted out LSB-first; fills with product low half
   logic [WIDTH-1:0]   acc_q,   acc_d;     // accumulator upper half
   logic [CW-1:0]      cnt_q,   cnt_d;
   logic               neg_q,   neg_d;
   logic               long_q,  long_d;
   logic [3:0]         a3_q,    a3_d;
   logic [3:0]         a4_q,    a4_d;
   logic [WIDTH-1:0]   lo_q,    lo_d;
   logic [WIDTH-1:0]   hi_q,    hi_d;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] res;

   // Next-state, datapath step and result capture
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      long_d  = long_q;
      a3_d    = a3_q;
      a4_d    = a4_q;
      lo_d    = lo_q;
      hi_d    = hi_q;

      // carry-out of the upper-half add is kept as the bit shifted back in
      sum  = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      prod = {acc_q, mplr_q};
      res  = neg_q ? -prod : prod;

      case (state_q)
         IDLE: begin
            if (start) begin
               long_d  = long_en;
               a3_d    = rd_lo;
               a4_d    = rd_hi;
               // magnitude of the most-negative value wraps to itself, which is correct unsigned
               mcand_d = (is_signed && a[WIDTH-1]) ? -a : a;
               mplr_d  = (is_signed && b[WIDTH-1]) ? -b : b;
               neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d  = sum[WIDTH:1];
            mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            lo_d    = res[WIDTH-1:0];
            hi_d    = long_q ? res[2*WIDTH-1:WIDTH] : '0;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         long_q  <= 1'b0;
         a3_q    <= '0;
         a4_q    <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         long_q  <= long_d;
         a3_q    <= a3_d;
         a4_q    <= a4_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign we       = done;
   assign long_out = long_q;
   assign a3       = a3_q;
   assign a4       = a4_q;
   assign lo       = lo_q;
   assign hi       = hi_q;

endmodule
